// File: rtl/spi_command_pkg.sv
// Shared types and constants for the SPI command interface.
package spi_command_pkg;

    localparam int BYTE_WIDTH  = 8;
    localparam int OPCODE_BITS = BYTE_WIDTH;
    localparam int BIT_CNT_W   = $clog2(BYTE_WIDTH);
    localparam int COUNT_W     = 32;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(BYTE_WIDTH - 1);
    localparam logic [COUNT_W-1:0]   COUNT_MAX = 32'h7FFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        OPCODE,
        OPERAND
    } state_e;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == COUNT_MAX) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/spi_input_synchronizer.sv
// Multi-flop synchroniser for an asynchronous SPI pin, with registered-copy edge detect.
module spi_input_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_command_interface.sv
// SPI mode-0 peripheral front-end: frames op-code/operand bytes and returns responder bytes on CIPO.
// Define SPI_TRANSACTION_TIMEOUT_EN to abort a transaction after TIMEOUT_CYCLES without an SCK edge.
//   state   | meaning
//   IDLE    | deselected or aborted; only a CS falling edge starts a transaction
//   OPCODE  | shifting the first byte; CIPO sends 0x00
//   OPERAND | shifting operand bytes; responder byte loaded at each byte boundary
module spi_command_interface
    import spi_command_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef SPI_TRANSACTION_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 72000
`endif
) (
    input  logic                   clock_spi_in,
    input  logic                   reset_spi_in,
    input  logic                   spi_select_n_in,
    input  logic                   spi_clock_in,
    input  logic                   spi_data_in,
    output logic                   spi_data_out,
    output logic [OPCODE_BITS-1:0] op_code_out,
    output logic                   op_code_valid_out,
    output logic [BYTE_WIDTH-1:0]  operand_out,
    output logic                   operand_valid_out,
    output logic [COUNT_W-1:0]     operand_count_out,
    input  logic [BYTE_WIDTH-1:0]  response_in,
    input  logic                   response_valid_in
);

    logic cs_lvl, cs_rise, cs_fall;
    logic sck_lvl_unused, sck_rise, sck_fall;
    logic copi_lvl;
    logic [SYNC_STAGES-1:0] copi_sync_q;
    logic timeout_hit;

    spi_input_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk_i   (clock_spi_in),
        .rst_i   (reset_spi_in),
        .async_i (spi_select_n_in),
        .level_o (cs_lvl),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    spi_input_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk_i   (clock_spi_in),
        .rst_i   (reset_spi_in),
        .async_i (spi_clock_in),
        .level_o (sck_lvl_unused),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    // Same depth as the SCK chain so data stays aligned with the sampling edge.
    always_ff @(posedge clock_spi_in or posedge reset_spi_in) begin
        if (reset_spi_in) copi_sync_q <= '0;
        else              copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], spi_data_in};
    end
    assign copi_lvl = copi_sync_q[SYNC_STAGES-1];

`ifdef SPI_TRANSACTION_TIMEOUT_EN
    logic [31:0] tmo_cnt_q;

    assign timeout_hit = (tmo_cnt_q == 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clock_spi_in or posedge reset_spi_in) begin
        if (reset_spi_in)                       tmo_cnt_q <= '0;
        else if (cs_lvl || sck_rise || sck_fall) tmo_cnt_q <= '0;
        else if (!timeout_hit)                  tmo_cnt_q <= tmo_cnt_q + 32'd1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    state_e                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BYTE_WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic [BYTE_WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic                   data_out_q, data_out_d;
    logic [OPCODE_BITS-1:0] op_code_q, op_code_d;
    logic                   op_code_valid_q, op_code_valid_d;
    logic [BYTE_WIDTH-1:0]  operand_q, operand_d;
    logic                   operand_valid_q, operand_valid_d;
    logic [COUNT_W-1:0]     count_q, count_d;
    logic [BYTE_WIDTH-1:0]  rx_byte, load_byte;
    logic                   selected;

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        rx_shift_d      = rx_shift_q;
        tx_shift_d      = tx_shift_q;
        data_out_d      = data_out_q;
        op_code_d       = op_code_q;
        op_code_valid_d = op_code_valid_q;
        operand_d       = operand_q;
        operand_valid_d = operand_valid_q;
        count_d         = count_q;
        rx_byte         = {rx_shift_q[BYTE_WIDTH-2:0], copi_lvl};
        load_byte       = response_valid_in ? response_in : '0;
        selected        = ~cs_lvl;

        // CS rise (or timeout) beats any SCK edge seen in the same cycle.
        if (state_q != IDLE && (cs_rise || timeout_hit)) begin
            state_d         = IDLE;
            bit_cnt_d       = '0;
            rx_shift_d      = '0;
            tx_shift_d      = '0;
            data_out_d      = 1'b0;
            op_code_valid_d = 1'b0;
            operand_valid_d = 1'b0;
            count_d         = '0;
        end else if (state_q == IDLE) begin
            if (cs_fall) begin
                state_d    = OPCODE;
                bit_cnt_d  = '0;
                rx_shift_d = '0;
                tx_shift_d = '0;
                data_out_d = 1'b0;
                count_d    = '0;
            end
        end else if (selected && sck_rise) begin
            rx_shift_d = rx_byte;
            bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
            if (state_q == OPERAND && bit_cnt_q == '0) operand_valid_d = 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
                if (state_q == OPCODE) begin
                    op_code_d       = rx_byte;
                    op_code_valid_d = 1'b1;
                    state_d         = OPERAND;
                end else begin
                    operand_d       = rx_byte;
                    operand_valid_d = 1'b1;
                    count_d         = sat_inc(count_q);
                end
            end
        end else if (selected && sck_fall) begin
            // Bit counter back at 0 in OPERAND means a byte has just completed.
            if (state_q == OPERAND && bit_cnt_q == '0) begin
                tx_shift_d = load_byte;
                data_out_d = load_byte[BYTE_WIDTH-1];
            end else begin
                tx_shift_d = {tx_shift_q[BYTE_WIDTH-2:0], 1'b0};
                data_out_d = tx_shift_q[BYTE_WIDTH-2];
            end
        end
    end

    always_ff @(posedge clock_spi_in or posedge reset_spi_in) begin
        if (reset_spi_in) begin
            state_q         <= IDLE;
            bit_cnt_q       <= '0;
            rx_shift_q      <= '0;
            tx_shift_q      <= '0;
            data_out_q      <= 1'b0;
            op_code_q       <= '0;
            op_code_valid_q <= 1'b0;
            operand_q       <= '0;
            operand_valid_q <= 1'b0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            rx_shift_q      <= rx_shift_d;
            tx_shift_q      <= tx_shift_d;
            data_out_q      <= data_out_d;
            op_code_q       <= op_code_d;
            op_code_valid_q <= op_code_valid_d;
            operand_q       <= operand_d;
            operand_valid_q <= operand_valid_d;
            count_q         <= count_d;
        end
    end

    assign spi_data_out      = data_out_q;
    assign op_code_out       = op_code_q;
    assign op_code_valid_out = op_code_valid_q;
    assign operand_out       = operand_q;
    assign operand_valid_out = operand_valid_q;
    assign operand_count_out = count_q;

endmodule

// File: tb/tb_spi_command_interface.sv
// Self-checking bench for spi_command_interface: table of transactions plus abort/reset/timeout sequences.
module tb_spi_command_interface;

    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic        sck = 1'b0;
    logic        copi = 1'b0;
    logic        cipo;
    logic [7:0]  op_code;
    logic        op_code_valid;
    logic [7:0]  operand;
    logic        operand_valid;
    logic [31:0] operand_count;
    logic [7:0]  resp;
    logic        resp_valid;
    int          resp_mode = 0;

    int n_tests = 0;
    int n_fail  = 0;
    int ov_rises = 0;
    logic ov_prev = 1'b0;

    typedef struct packed {
        logic [7:0]  data;
        logic [31:0] cnt;
    } op_exp_t;

    logic [7:0] cipo_q[$];
    op_exp_t    op_q[$];

    typedef struct {
        logic [7:0]      opcode;
        int              n_ops;
        logic [5:0][7:0] ops;
        int              resp_mode;
        logic [5:0][7:0] exp_cipo;
        logic [31:0]     exp_count;
    } vec_t;

    vec_t tbl[4];

    always #7 clk = ~clk;

    spi_command_interface #(
        .SYNC_STAGES(2)
`ifdef SPI_TRANSACTION_TIMEOUT_EN
        , .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .clock_spi_in      (clk),
        .reset_spi_in      (rst),
        .spi_select_n_in   (cs_n),
        .spi_clock_in      (sck),
        .spi_data_in       (copi),
        .spi_data_out      (cipo),
        .op_code_out       (op_code),
        .op_code_valid_out (op_code_valid),
        .operand_out       (operand),
        .operand_valid_out (operand_valid),
        .operand_count_out (operand_count),
        .response_in       (resp),
        .response_valid_in (resp_valid)
    );

    // Responder model keyed on the DUT's operand index.
    always_comb begin
        resp       = 8'h00;
        resp_valid = 1'b0;
        case (resp_mode)
            1: begin
                if (operand_count == 32'd0) begin resp = 8'h9C; resp_valid = 1'b1; end
                else if (operand_count == 32'd1) begin resp = 8'h40; resp_valid = 1'b1; end
            end
            2: begin resp = operand_count[7:0]; resp_valid = 1'b1; end
            3: begin resp = 8'hE7; resp_valid = 1'b0; end
            default: ;
        endcase
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [5:0][7:0] b6(input logic [7:0] a0, a1, a2, a3, a4, a5);
        return {a5, a4, a3, a2, a1, a0};
    endfunction

    // Operand scoreboard: popped on every 0->1 of operand_valid.
    always @(negedge clk) begin
        if (operand_valid && !ov_prev) begin
            ov_rises++;
            if (op_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL operand_unexpected: got 0x%0h with nothing expected", operand);
            end else begin
                op_exp_t e;
                e = op_q.pop_front();
                check("operand_byte", {24'h0, operand}, {24'h0, e.data});
                check("operand_count_at_valid", operand_count, e.cnt);
            end
        end
        ov_prev = operand_valid;
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            copi = tx[i];
            clk_wait(HALF);
            sck = 1'b1;
            rx[i] = cipo;
            clk_wait(HALF);
            sck = 1'b0;
        end
    endtask

    function automatic void sb_cipo(input logic [7:0] rx);
        if (cipo_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL cipo_unexpected: got 0x%0h with nothing expected", rx);
        end else begin
            logic [7:0] e;
            e = cipo_q.pop_front();
            check("cipo_byte", {24'h0, rx}, {24'h0, e});
        end
    endfunction

    task automatic run_vec(input vec_t v);
        logic [7:0] rx;
        int rises0;
        rises0 = ov_rises;
        resp_mode = v.resp_mode;
        for (int b = 0; b <= v.n_ops; b++) cipo_q.push_back(v.exp_cipo[b]);
        for (int k = 0; k < v.n_ops; k++) op_q.push_back('{data: v.ops[k], cnt: 32'(k + 1)});
        cs_n = 1'b0;
        clk_wait(HALF);
        check("opvalid_before_byte", {31'h0, op_code_valid}, 32'h0);
        xfer_bits(v.opcode, 8, rx);
        sb_cipo(rx);
        clk_wait(3);
        check("op_code", {24'h0, op_code}, {24'h0, v.opcode});
        check("op_code_valid", {31'h0, op_code_valid}, 32'h1);
        for (int k = 0; k < v.n_ops; k++) begin
            xfer_bits(v.ops[k], 8, rx);
            sb_cipo(rx);
        end
        clk_wait(3);
        check("count_end", operand_count, v.exp_count);
        cs_n = 1'b1;
        clk_wait(6);
        check("opvalid_after_cs", {31'h0, op_code_valid}, 32'h0);
        check("operand_valid_after_cs", {31'h0, operand_valid}, 32'h0);
        check("count_after_cs", operand_count, 32'h0);
        check("cipo_after_cs", {31'h0, cipo}, 32'h0);
        check("op_code_retained", {24'h0, op_code}, {24'h0, v.opcode});
        if (v.n_ops > 0)
            check("operand_retained", {24'h0, operand}, {24'h0, v.ops[v.n_ops-1]});
        check("operand_rises", 32'(ov_rises - rises0), 32'(v.n_ops));
        resp_mode = 0;
        clk_wait(4);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx_unused;

        tbl[0] = '{opcode: 8'h20, n_ops: 0, ops: b6(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00),
                   resp_mode: 0, exp_cipo: b6(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), exp_count: 32'd0};
        tbl[1] = '{opcode: 8'h21, n_ops: 2, ops: b6(8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00),
                   resp_mode: 1, exp_cipo: b6(8'h00, 8'h9C, 8'h40, 8'h00, 8'h00, 8'h00), exp_count: 32'd2};
        tbl[2] = '{opcode: 8'h22, n_ops: 5, ops: b6(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00),
                   resp_mode: 2, exp_cipo: b6(8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04), exp_count: 32'd5};
        tbl[3] = '{opcode: 8'hA5, n_ops: 3, ops: b6(8'h80, 8'h01, 8'h7E, 8'h00, 8'h00, 8'h00),
                   resp_mode: 3, exp_cipo: b6(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), exp_count: 32'd3};

        clk_wait(3);
        check("rst_op_code", {24'h0, op_code}, 32'h0);
        check("rst_op_valid", {31'h0, op_code_valid}, 32'h0);
        check("rst_operand", {24'h0, operand}, 32'h0);
        check("rst_operand_valid", {31'h0, operand_valid}, 32'h0);
        check("rst_count", operand_count, 32'h0);
        check("rst_cipo", {31'h0, cipo}, 32'h0);
        rst = 1'b0;
        clk_wait(6);

        for (int i = 0; i < 4; i++) run_vec(tbl[i]);

        // Abort part-way through the second operand.
        cs_n = 1'b0;
        cipo_q.push_back(8'h00);
        cipo_q.push_back(8'h00);
        op_q.push_back('{data: 8'h5A, cnt: 32'd1});
        clk_wait(HALF);
        xfer_bits(8'h23, 8, rx_unused);
        sb_cipo(rx_unused);
        xfer_bits(8'h5A, 8, rx_unused);
        sb_cipo(rx_unused);
        xfer_bits(8'hC3, 5, rx_unused);
        clk_wait(3);
        check("abort_mid_valid", {31'h0, operand_valid}, 32'h0);
        check("abort_mid_count", operand_count, 32'h1);
        cs_n = 1'b1;
        clk_wait(6);
        check("abort_valid", {31'h0, operand_valid}, 32'h0);
        check("abort_count", operand_count, 32'h0);
        check("abort_operand_kept", {24'h0, operand}, 32'h5A);
        check("abort_opvalid", {31'h0, op_code_valid}, 32'h0);
        clk_wait(4);
        run_vec(tbl[3]);

        // Reset mid-byte with CS held low.
        cs_n = 1'b0;
        clk_wait(HALF);
        xfer_bits(8'h20, 8, rx_unused);
        xfer_bits(8'hFF, 3, rx_unused);
        rst = 1'b1;
        clk_wait(1);
        check("midrst_op_code", {24'h0, op_code}, 32'h0);
        check("midrst_op_valid", {31'h0, op_code_valid}, 32'h0);
        check("midrst_operand", {24'h0, operand}, 32'h0);
        check("midrst_count", operand_count, 32'h0);
        check("midrst_cipo", {31'h0, cipo}, 32'h0);
        rst = 1'b0;
        clk_wait(4);
        xfer_bits(8'h66, 8, rx_unused);
        clk_wait(3);
        check("postrst_no_decode_valid", {31'h0, op_code_valid}, 32'h0);
        check("postrst_no_decode_op", {24'h0, op_code}, 32'h0);
        cs_n = 1'b1;
        clk_wait(8);

        // CS rise coincident with the 8th SCK rise: the byte must be dropped.
        cs_n = 1'b0;
        clk_wait(HALF);
        xfer_bits(8'h77, 7, rx_unused);
        copi = 1'b1;
        clk_wait(HALF);
        sck = 1'b1;
        cs_n = 1'b1;
        clk_wait(HALF);
        sck = 1'b0;
        clk_wait(4);
        check("cs_wins_valid", {31'h0, op_code_valid}, 32'h0);
        check("cs_wins_op", {24'h0, op_code}, 32'h0);

        // Stalled transaction: holds without the timeout, aborts with it.
        begin
            logic stall_exp_valid;
`ifdef SPI_TRANSACTION_TIMEOUT_EN
            stall_exp_valid = 1'b0;
`else
            stall_exp_valid = 1'b1;
            op_q.push_back('{data: 8'h55, cnt: 32'd1});
`endif
            cs_n = 1'b0;
            clk_wait(HALF);
            xfer_bits(8'h31, 8, rx_unused);
            clk_wait(80);
            check("stall_early_valid", {31'h0, op_code_valid}, 32'h1);
            clk_wait(50);
            check("stall_late_valid", {31'h0, op_code_valid}, {31'h0, stall_exp_valid});
            xfer_bits(8'h55, 8, rx_unused);
            clk_wait(3);
            check("stall_sck_after", {31'h0, operand_valid}, {31'h0, stall_exp_valid});
            cs_n = 1'b1;
            clk_wait(8);
        end

        check("operand_queue_left", 32'(op_q.size()), 32'h0);
        check("cipo_queue_left", 32'(cipo_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
